// File: rtl/addsub_serial.sv
// Bit-serial (SLICE bits per clock) adder/subtractor with valid/ready handshake and {C,N,Z,V} flags.
// Optional saturation on signed overflow is enabled by defining ADDSUB_SERIAL_SAT_EN (adds port sat).
module addsub_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
`ifdef ADDSUB_SERIAL_SAT_EN
    ,
    input  logic             sat
`endif
);
    localparam int unsigned NSL = WIDTH / SLICE;
    localparam int unsigned CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int unsigned IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_sub;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
`ifdef ADDSUB_SERIAL_SAT_EN
    logic             r_sat;
`endif

    logic [WIDTH-1:0] w_b_eff;
    logic [IW-1:0]    w_base;
    logic [SLICE:0]   w_slice;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_out;
    logic             w_last;
    logic             w_c;
    logic             w_v;

    assign w_b_eff   = r_sub ? ~r_b : r_b;
    assign w_base    = IW'(32'(r_cnt) * SLICE);
    assign w_last    = (r_cnt == LAST);
    assign w_slice   = {1'b0, r_a[w_base +: SLICE]} + {1'b0, w_b_eff[w_base +: SLICE]}
                     + {{SLICE{1'b0}}, r_carry};
    assign w_c       = w_slice[SLICE];
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    // Full result including the slice being written this cycle; only meaningful on the last slice.
    always_comb begin
        w_res = r_acc;
        w_res[w_base +: SLICE] = w_slice[SLICE-1:0];
        w_v   = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
        w_out = w_res;
`ifdef ADDSUB_SERIAL_SAT_EN
        if (r_sat && w_v) begin
            w_out = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            out     <= '0;
            flags   <= '0;
`ifdef ADDSUB_SERIAL_SAT_EN
            r_sat   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in1;
                        r_b     <= in2;
                        r_sub   <= sub;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_acc   <= '0;
`ifdef ADDSUB_SERIAL_SAT_EN
                        r_sat   <= sat;
`endif
                    end
                end
                RUN: begin
                    r_acc   <= w_res;
                    r_carry <= w_c;
                    if (w_last) begin
                        out   <= w_out;
                        flags <= {w_c, w_out[WIDTH-1], ~|w_out, w_v};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench: three addsub_serial instances (SLICE 1, 4, 16) driven in lockstep
// against an integer-arithmetic reference model; directed cases plus a random sweep.
`timescale 1ns/1ps
module tb_addsub_serial;
    localparam int W  = 16;
    localparam int ND = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic         out_ready = 1'b0;
    logic         sat = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;

    logic         d_in_ready [ND];
    logic         d_out_valid[ND];
    logic [W-1:0] d_out      [ND];
    logic [3:0]   d_flags    [ND];

    logic [W-1:0] prev_out  [ND];
    logic [3:0]   prev_flags[ND];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned SL = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        addsub_serial #(.WIDTH(W), .SLICE(SL)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (d_in_ready[g]),
            .in1       (in1),
            .in2       (in2),
            .sub       (sub),
            .out_valid (d_out_valid[g]),
            .out_ready (out_ready),
            .out       (d_out[g]),
            .flags     (d_flags[g])
`ifdef ADDSUB_SERIAL_SAT_EN
            ,
            .sat       (sat)
`endif
        );
    end

    function automatic int lat_exp(input int g);
        return (g == 0) ? 16 : ((g == 1) ? 4 : 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: signed/unsigned integer arithmetic, independent of any slicing.
    function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic s, input logic sa,
                                      output logic [W-1:0] r, output logic [3:0] f);
        int ua, ub, sa_i, sb_i, st, ures;
        logic c, v;
        ua   = int'(a);
        ub   = int'(b);
        sa_i = int'($signed(a));
        sb_i = int'($signed(b));
        if (s) begin
            ures = ua - ub;
            c    = (ua >= ub);
            st   = sa_i - sb_i;
        end else begin
            ures = ua + ub;
            c    = (ures >= 65536);
            st   = sa_i + sb_i;
        end
        r = W'(ures);
        v = (st > 32767) || (st < -32768);
        if (sa && v) r = (st > 0) ? 16'h7FFF : 16'h8000;
        f = {c, r[W-1], (r == '0), v};
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic sa, input logic [W-1:0] eo, input logic [3:0] ef,
                         input bit hold);
        int lat[ND];
        bit all;
        for (int g = 0; g < ND; g++) check("in_ready_idle", d_in_ready[g], 1);
        in1 = a; in2 = b; sub = s; sat = sa; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        in1 = W'($urandom); in2 = W'($urandom); sub = 1'($urandom); sat = 1'($urandom);
        for (int g = 0; g < ND; g++) begin
            lat[g] = 0;
            check("run_out_retained", d_out[g], prev_out[g]);
            check("run_flags_retained", d_flags[g], prev_flags[g]);
            check("run_in_ready_low", d_in_ready[g], 0);
        end
        all = 1'b0;
        for (int c = 1; c <= 40 && !all; c++) begin
            step;
            all = 1'b1;
            for (int g = 0; g < ND; g++) begin
                if (d_out_valid[g] && lat[g] == 0) lat[g] = c;
                if (lat[g] == 0) all = 1'b0;
            end
        end
        for (int g = 0; g < ND; g++) begin
            check("latency", lat[g], lat_exp(g));
            check("result", d_out[g], eo);
            check("flags", d_flags[g], ef);
        end
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                in_valid = k[0];
                in1 = W'($urandom); in2 = W'($urandom); sub = 1'($urandom);
                step;
                for (int g = 0; g < ND; g++) begin
                    check("hold_out", d_out[g], eo);
                    check("hold_flags", d_flags[g], ef);
                    check("hold_out_valid", d_out_valid[g], 1);
                    check("hold_in_ready", d_in_ready[g], 0);
                end
            end
        end
        in_valid  = hold;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        for (int g = 0; g < ND; g++) begin
            check("release_out_valid", d_out_valid[g], 0);
            check("release_in_ready", d_in_ready[g], 1);
            check("release_out_kept", d_out[g], eo);
            prev_out[g]   = eo;
            prev_flags[g] = ef;
        end
    endtask

    task automatic rand_op;
        logic [W-1:0] a, b, r;
        logic s, sa;
        logic [3:0] f;
        a  = W'($urandom);
        b  = W'($urandom);
        case ($urandom_range(0, 5))
            0: a = 16'h7FFF;
            1: b = 16'h8000;
            2: b = a;
            default: ;
        endcase
        s  = 1'($urandom);
`ifdef ADDSUB_SERIAL_SAT_EN
        sa = 1'($urandom);
`else
        sa = 1'b0;
`endif
        ref_model(a, b, s, sa, r, f);
        do_op(a, b, s, sa, r, f, 1'b0);
    endtask

    initial begin
        int ov_seen;
        for (int g = 0; g < ND; g++) begin
            prev_out[g]   = '0;
            prev_flags[g] = '0;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < ND; g++) begin
            check("reset_out", d_out[g], 0);
            check("reset_flags", d_flags[g], 0);
            check("reset_in_ready", d_in_ready[g], 1);
            check("reset_out_valid", d_out_valid[g], 0);
        end
        repeat (2) step;
        @(negedge clk) rst_n = 1'b1;
        step;

        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b0101, 1'b1);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1010, 1'b0);
        do_op(16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 4'b1010, 1'b0);
        do_op(16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 4'b0100, 1'b0);

        // Abort mid-operation with an asynchronous reset pulse.
        in1 = 16'hAAAA; in2 = 16'h5555; sub = 1'b0; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < ND; g++) begin
            check("abort_out", d_out[g], 0);
            check("abort_flags", d_flags[g], 0);
            check("abort_in_ready", d_in_ready[g], 1);
            check("abort_out_valid", d_out_valid[g], 0);
            prev_out[g]   = '0;
            prev_flags[g] = '0;
        end
        @(negedge clk) rst_n = 1'b1;
        ov_seen = 0;
        for (int k = 0; k < 20; k++) begin
            step;
            for (int g = 0; g < ND; g++) if (d_out_valid[g]) ov_seen++;
        end
        check("abort_no_out_valid", ov_seen, 0);
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 4'b0000, 1'b0);

`ifdef ADDSUB_SERIAL_SAT_EN
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b0001, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b1101, 1'b0);
`endif

        for (int n = 0; n < 40; n++) rand_op();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 4, bits added per clock cycle; SHALL satisfy 1 <= SLICE <= WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands and op presented.
REQ-006 in_ready  output  1  block accepts a new operation.
REQ-007 in1  input  WIDTH  first operand (A).
REQ-008 in2  input  WIDTH  second operand (B).
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out  output  WIDTH  result.
REQ-013 flags  output  4  {C,N,Z,V}, bit 3 = C, bit 0 = V.

Function
REQ-014 Block SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE with in_valid=1 SHALL capture in1, in2 and sub, load carry = sub, clear slice counter, and go to RUN.
REQ-017 Captured operands SHALL NOT change while in RUN or DONE; in1/in2/sub changes SHALL be ignored.
REQ-018 Each RUN cycle SHALL add slice k of A, slice k of (sub ? ~B : B) and the carry register; it SHALL write the SLICE-bit sum into slice k of the result and the carry-out into the carry register.
REQ-019 Slices SHALL be processed LSB first; the counter SHALL run 0..WIDTH/SLICE-1.
REQ-020 After the last slice, the FSM SHALL go to DONE; out_valid SHALL rise exactly WIDTH/SLICE cycles after the accepting edge (4 cycles at defaults).
REQ-021 When SLICE = WIDTH, latency SHALL be 1 cycle.
REQ-022 C SHALL be the carry out of bit WIDTH-1; for sub=1, C=1 means no borrow.
REQ-023 V SHALL be 1 when A[MSB] equals the effective B[MSB] and result[MSB] differs from them.
REQ-024 N SHALL be out[WIDTH-1]; Z SHALL be 1 if and only if out is all zero.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-026 In DONE, out and flags SHALL hold stable until out_ready=1.
REQ-027 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge.
REQ-028 A new operation SHALL NOT be accepted in that same cycle; the minimum period between operations is WIDTH/SLICE+2 cycles.
REQ-029 out and flags SHALL retain the last result while in IDLE and RUN.

Reset
REQ-030 rst_n=0 SHALL, asynchronously, force state IDLE, in_ready=1, out_valid=0, out=0, flags=4'b0000, and clear the counter, carry and operand registers.
REQ-031 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid pulse SHALL follow deassertion.
REQ-032 After deassertion, the first accepting edge SHALL be the first clk rise with in_valid=1.

Configuration
REQ-033 Macro ADDSUB_SERIAL_SAT_EN, when defined, SHALL add input port sat (1 bit), captured with the operands.
REQ-034 With the macro defined, sat=1 and V=1: out SHALL clamp to signed max (0x7FFF at defaults) for positive overflow and signed min (0x8000) for negative overflow.
REQ-035 In the clamped case, C and V SHALL come from the unclamped arithmetic; N and Z SHALL come from the clamped out.
REQ-036 Without the macro, the sat port SHALL NOT exist and results SHALL always wrap.

Verification (WIDTH=16, SLICE=4)
REQ-037 Stimulus: 0x7FFF+0x0001, sub=0 -> out=0x8000, flags=4'b0101, out_valid 4 cycles after acceptance.
REQ-038 Stimulus: 0xFFFF+0x0001 -> out=0x0000, flags=4'b1010; then 0x0005-0x0005 -> out=0x0000, flags=4'b1010; then 0x0003-0x0005 -> out=0xFFFE, flags=4'b0100.
REQ-039 Stimulus: out_ready held 0 for 10 cycles after out_valid -> out, flags and out_valid stable; in_ready=0; in_valid pulses ignored.
REQ-040 Stimulus: rst_n pulsed low in RUN cycle 2 -> outputs reset immediately; no out_valid afterward; next op 0x1234+0x1111 -> 0x2345, flags=4'b0000.
REQ-041 With ADDSUB_SERIAL_SAT_EN and sat=1: 0x7FFF+0x0001 -> out=0x7FFF, flags=4'b0001; 0x8000-0x0001 -> out=0x8000, flags=4'b1101.
REQ-042 Random sweep at SLICE in {1,4,16} -> results and flags match the reference model; latency = WIDTH/SLICE.
